// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the ID/EX decode logic and the hazard controller.
// master: pipeline side (drives decode/EX status, receives stall controls).
// slave:  hazard controller.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_is_mul;
  logic             id_is_jump;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             ex_branch_tkn;

  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_stall;
  logic             idex_bubble;
  logic             exmem_bubble;
  logic             mul_busy;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mul, id_is_jump,
           ex_mem_read, ex_rd, ex_branch_tkn,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_bubble,
           mul_busy, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mul, id_is_jump,
           ex_mem_read, ex_rd, ex_branch_tkn,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_bubble,
           mul_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core.
// Resolves load-use stalls, taken-beq flushes, jump squash and multi-cycle mul
// occupancy of EX, and counts stalled cycles in a saturating counter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; hazards resolved combinationally by priority
// MUL_WAIT | mul held in EX; front end frozen, EX/MEM fed with nops
module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  localparam int MCW = $clog2(MUL_LAT + 1);
  localparam bit MUL_MULTI = (MUL_LAT > 1);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MUL_WAIT = 1'b1;

  logic [0:0]       state, next_state;
  logic [MCW-1:0]   mul_cnt, next_cnt;
  logic [CNT_W-1:0] stall_cycles;

  logic load_use;
  logic pc_stall_c, ifid_stall_c, ifid_flush_c, idex_stall_c;
  logic idex_bubble_c, exmem_bubble_c, mul_busy_c;

  // Load-use: the lw in EX writes a register the ID instruction reads; $zero never hazards.
  always_comb begin
    load_use = bus.id_valid & bus.ex_mem_read & (bus.ex_rd != 5'd0)
             & ((bus.id_uses_rs & (bus.id_rs == bus.ex_rd))
              | (bus.id_uses_rt & (bus.id_rt == bus.ex_rd)));
  end

  // Prioritised control decode and next-state; everything reads 0 while reset is high.
  always_comb begin
    pc_stall_c     = 1'b0;
    ifid_stall_c   = 1'b0;
    ifid_flush_c   = 1'b0;
    idex_stall_c   = 1'b0;
    idex_bubble_c  = 1'b0;
    exmem_bubble_c = 1'b0;
    mul_busy_c     = 1'b0;
    next_state     = state;
    next_cnt       = mul_cnt;
    if (!reset) begin
      if (state == RUN) begin
        if (bus.ex_branch_tkn) begin
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
        end else if (load_use) begin
          pc_stall_c    = 1'b1;
          ifid_stall_c  = 1'b1;
          idex_bubble_c = 1'b1;
        end else if (bus.id_valid & bus.id_is_jump) begin
          ifid_flush_c  = 1'b1;
        end else if (bus.id_valid & bus.id_is_mul & MUL_MULTI) begin
          next_state = MUL_WAIT;
          next_cnt   = MCW'(MUL_LAT - 1);
        end
      end else begin
        // EX holds the mul, so branch/load status from EX is meaningless here.
        pc_stall_c     = 1'b1;
        ifid_stall_c   = 1'b1;
        idex_stall_c   = 1'b1;
        exmem_bubble_c = 1'b1;
        mul_busy_c     = 1'b1;
        next_cnt       = mul_cnt - MCW'(1);
        if (mul_cnt <= MCW'(1)) begin
          next_state = RUN;
        end
      end
    end
  end

  // FSM state and mul occupancy counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      mul_cnt <= '0;
    end else begin
      state   <= next_state;
      mul_cnt <= next_cnt;
    end
  end

  // Saturating count of cycles with the PC held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (pc_stall_c && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  // Drive the bundle outputs.
  always_comb begin
    bus.pc_stall     = pc_stall_c;
    bus.ifid_stall   = ifid_stall_c;
    bus.ifid_flush   = ifid_flush_c;
    bus.idex_stall   = idex_stall_c;
    bus.idex_bubble  = idex_bubble_c;
    bus.exmem_bubble = exmem_bubble_c;
    bus.mul_busy     = mul_busy_c;
    bus.stall_cycles = stall_cycles;
  end

endmodule
